// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality decode, default widths
// and the operand bundle handed from operand fetch to the ALU.
package alu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned REG_W = 5;

   localparam logic [OP_W-1:0] ADD = 6'b011000;
   localparam logic [OP_W-1:0] SUB = 6'b011001;
   localparam logic [OP_W-1:0] XOR = 6'b101111;
   localparam logic [OP_W-1:0] OR  = 6'b101110;
   localparam logic [OP_W-1:0] AND = 6'b010101;
   localparam logic [OP_W-1:0] SRA = 6'b100100;
   localparam logic [OP_W-1:0] SRL = 6'b100101;
   localparam logic [OP_W-1:0] SLL = 6'b100111;
   localparam logic [OP_W-1:0] LT  = 6'b000000;
   localparam logic [OP_W-1:0] LTU = 6'b000001;
   localparam logic [OP_W-1:0] GT  = 6'b001010;
   localparam logic [OP_W-1:0] GTU = 6'b001011;
   localparam logic [OP_W-1:0] EQ  = 6'b001100;
   localparam logic [OP_W-1:0] NE  = 6'b001101;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [REG_W-1:0] rd;
   } issue_bundle_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      case (op)
         ADD, SUB, XOR, OR, AND, SRA, SRL, SLL,
         LT, LTU, GT, GTU, EQ, NE: is_legal_op = 1'b1;
         default:                  is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous
// write port; register 0 is hardwired to zero.
module regfile_2r1w #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            wen,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs [NREG];

   // Reset has priority, so a write presented during reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      end else if (wen && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand fetch / issue stage: reads and bypasses sources, blocks on the
// busy scoreboard and holds one registered operand bundle for the ALU.
module alu_operand_fetch
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = alu_pkg::XLEN,
   parameter int unsigned NREG = alu_pkg::NREG
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [REG_W-1:0] in_rd,
   input  logic [REG_W-1:0] in_rs1,
   input  logic [REG_W-1:0] in_rs2,
   input  logic             in_use_imm,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             wb_en,
   input  logic [REG_W-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OP_W-1:0]  out_op,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [REG_W-1:0] out_rd,
   output logic             out_illegal
);

   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;
   logic [XLEN-1:0] opnd_a;
   logic [XLEN-1:0] opnd_b;
   logic            byp_rs1;
   logic            byp_rs2;
   logic            haz_rs1;
   logic            haz_rs2;
   logic            haz_rd;
   logic            hazard;
   logic            accept;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            out_valid_q;
   issue_bundle_t   out_q;

   regfile_2r1w #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .raddr1 (in_rs1),
      .raddr2 (in_rs2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2),
      .wen    (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   // Same-cycle write-back forwarding; register 0 never forwards.
   assign byp_rs1 = wb_en && (wb_rd == in_rs1) && (in_rs1 != '0);
   assign byp_rs2 = wb_en && (wb_rd == in_rs2) && (in_rs2 != '0);
   assign opnd_a  = byp_rs1 ? wb_data : rf_rdata1;
   assign opnd_b  = in_use_imm ? in_imm : (byp_rs2 ? wb_data : rf_rdata2);

   // A busy register being written back this cycle no longer blocks.
   assign haz_rs1 = busy_q[in_rs1] && !(wb_en && wb_rd == in_rs1);
   assign haz_rs2 = !in_use_imm && busy_q[in_rs2] && !(wb_en && wb_rd == in_rs2);
   assign haz_rd  = busy_q[in_rd] && !(wb_en && wb_rd == in_rd);
   assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

   assign in_ready = !reset && !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Issue-set is applied after write-back clear so it wins on collision.
   always_comb begin
      busy_d = busy_q;
      if (wb_en && wb_rd != '0) busy_d[wb_rd] = 1'b0;
      if (accept && in_rd != '0) busy_d[in_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_q.op    <= in_op;
            out_q.a     <= opnd_a;
            out_q.b     <= opnd_b;
            out_q.rd    <= in_rd;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_op      = out_q.op;
   assign out_a       = out_q.a;
   assign out_b       = out_q.b;
   assign out_rd      = out_q.rd;
   assign out_illegal = !is_legal_op(out_q.op);

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: directed scenarios followed by
// randomized traffic against a behavioural register/scoreboard model.
module tb_alu_operand_fetch;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic        in_use_imm;
   logic [31:0] in_imm;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] legal_ops [14] = '{6'b011000, 6'b011001, 6'b101111, 6'b101110,
                                  6'b010101, 6'b100100, 6'b100101, 6'b100111,
                                  6'b000000, 6'b000001, 6'b001010, 6'b001011,
                                  6'b001100, 6'b001101};

   alu_operand_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_use_imm  (in_use_imm),
      .in_imm      (in_imm),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_use_imm = 1'b0; in_imm = '0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      out_ready = 1'b1;
   endtask

   task automatic drive_issue(input logic [5:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use_imm, input logic [31:0] imm);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_use_imm = use_imm; in_imm = imm;
   endtask

   task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
      wb_en = en; wb_rd = rd; wb_data = data;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      drive_wb(1'b1, 5'd1, 32'hDEAD_BEEF);
      drive_issue(ADD, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      step();
      step();
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b op=%h a=%h b=%h rd=%0d want all 0",
                  out_valid, out_op, out_a, out_b, out_rd);
      end
      reset = 1'b0;
      drive_wb(1'b0, 5'd0, 32'd0);
      drive_issue(ADD, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_a !== 32'd0) begin
         n_fail++; $display("FAIL reset_wb_ignored: valid=%b a=%h want 1/0", out_valid, out_a);
      end
   endtask

   task automatic test_add_issue();
      drive_wb(1'b1, 5'd1, 32'd5);
      step();
      drive_wb(1'b1, 5'd2, 32'd6);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      drive_issue(ADD, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL add_ready: got %b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd, out_illegal} !== {1'b1, ADD, 32'd5, 32'd6, 5'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL add_bundle: valid=%b op=%h a=%0d b=%0d rd=%0d ill=%b want 1/18/5/6/3/0",
                  out_valid, out_op, out_a, out_b, out_rd, out_illegal);
      end
   endtask

   task automatic test_raw_bypass();
      drive_issue(SUB, 5'd4, 5'd3, 5'd0, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL raw_stall: in_ready=%b want 0", in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL raw_drain: out_valid=%b want 0", out_valid);
      end
      drive_wb(1'b1, 5'd3, 32'd11);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL raw_unblock: in_ready=%b want 1", in_ready);
      end
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd} !== {1'b1, SUB, 32'd11, 32'd0, 5'd4}) begin
         n_fail++;
         $display("FAIL raw_bypass: valid=%b op=%h a=%0d b=%0d rd=%0d want 1/19/11/0/4",
                  out_valid, out_op, out_a, out_b, out_rd);
      end
   endtask

   task automatic test_stall_hold();
      out_ready = 1'b0;
      drive_issue(ADD, 5'd5, 5'd1, 5'd2, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL hold_ready: in_ready=%b want 0", in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({out_valid, out_op, out_a, out_b, out_rd} !== {1'b1, SUB, 32'd11, 32'd0, 5'd4}) begin
            n_fail++;
            $display("FAIL hold_stable: cyc=%0d valid=%b op=%h a=%0d b=%0d rd=%0d want 1/19/11/0/4",
                     i, out_valid, out_op, out_a, out_b, out_rd);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd} !== {1'b1, ADD, 32'd5, 32'd6, 5'd5}) begin
         n_fail++;
         $display("FAIL hold_next: valid=%b op=%h a=%0d b=%0d rd=%0d want 1/18/5/6/5",
                  out_valid, out_op, out_a, out_b, out_rd);
      end
      drive_wb(1'b1, 5'd4, 32'h44);
      step();
      drive_wb(1'b1, 5'd5, 32'h55);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reg0();
      drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      drive_issue(XOR, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reg0_ready: in_ready=%b want 1", in_ready);
      end
      step();
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd} !== {1'b1, XOR, 32'd0, 32'd0, 5'd0}) begin
         n_fail++;
         $display("FAIL reg0_read: valid=%b op=%h a=%h b=%h rd=%0d want 1/2f/0/0/0",
                  out_valid, out_op, out_a, out_b, out_rd);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reg0_not_busy: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_imm();
      drive_issue(ADD, 5'd6, 5'd1, 5'd2, 1'b0, 32'd0);
      step();
      drive_issue(ADD, 5'd7, 5'd1, 5'd6, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL imm_rs2_stall: in_ready=%b want 0", in_ready);
      end
      in_use_imm = 1'b1;
      in_imm = 32'hFFFF_FFF8;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL imm_ready: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_a, out_b, out_rd} !== {1'b1, 32'd5, 32'hFFFF_FFF8, 5'd7}) begin
         n_fail++;
         $display("FAIL imm_bundle: valid=%b a=%h b=%h rd=%0d want 1/5/fffffff8/7",
                  out_valid, out_a, out_b, out_rd);
      end
      drive_wb(1'b1, 5'd6, 32'h66);
      step();
      drive_wb(1'b1, 5'd7, 32'h77);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_illegal();
      drive_issue(6'b111111, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL illegal_ready: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_op, out_illegal} !== {1'b1, 6'b111111, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_flag: valid=%b op=%h ill=%b want 1/3f/1", out_valid, out_op, out_illegal);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [4] = '{ADD, SUB, SLL, EQ};
      for (int i = 0; i < 4; i++) begin
         drive_issue(ops[i], 5'(10 + i), 5'd1, 5'd0, 1'b1, 32'(100 + i));
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: i=%0d in_ready=%b want 1", i, in_ready);
         end
         step();
         n_checks++;
         if ({out_valid, out_op, out_b, out_rd} !== {1'b1, ops[i], 32'(100 + i), 5'(10 + i)}) begin
            n_fail++;
            $display("FAIL b2b_bundle: i=%0d valid=%b op=%h b=%0d rd=%0d want 1/%h/%0d/%0d",
                     i, out_valid, out_op, out_b, out_rd, ops[i], 100 + i, 10 + i);
         end
      end
      in_valid = 1'b0;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 5'(10 + i), 32'(i));
         step();
      end
      drive_wb(1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset_mid_stall();
      drive_wb(1'b1, 5'd1, 32'h77);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
      out_ready = 1'b0;
      drive_issue(ADD, 5'd8, 5'd1, 5'd0, 1'b0, 32'd0);
      step();
      drive_issue(SUB, 5'd9, 5'd0, 5'd0, 1'b0, 32'd0);
      step();
      reset = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_ready: in_ready=%b want 0", in_ready);
      end
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_op, out_a, out_b, out_rd} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_drop: valid=%b op=%h a=%h b=%h rd=%0d want all 0",
                  out_valid, out_op, out_a, out_b, out_rd);
      end
      out_ready = 1'b1;
      drive_issue(ADD, 5'd9, 5'd1, 5'd8, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_busy_clear: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_a !== 32'd0) begin
         n_fail++; $display("FAIL mid_reset_reg_clear: valid=%b a=%h want 1/0", out_valid, out_a);
      end
      drive_wb(1'b1, 5'd9, 32'd0);
      step();
      drive_wb(1'b0, 5'd0, 32'd0);
   endtask

   // Reference model: architectural registers, busy set and the held bundle.
   logic [31:0] m_reg  [32];
   bit          m_busy [32];
   bit          m_valid;
   logic [5:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [4:0]  m_rd;

   function automatic bit m_blocks(input logic [4:0] r);
      return (r != 5'd0) && m_busy[r] && !(wb_en && wb_rd == r);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && wb_rd == r) return wb_data;
      return m_reg[r];
   endfunction

   function automatic bit m_legal(input logic [5:0] op);
      foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic test_random();
      bit         exp_ready;
      bit         acc;
      logic [4:0] pend [$];
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int r = 0; r < 32; r++) begin
         m_reg[r] = '0; m_busy[r] = 1'b0;
      end
      m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_op      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
         in_rd      = 5'($urandom_range(0, 7));
         in_rs1     = 5'($urandom_range(0, 7));
         in_rs2     = 5'($urandom_range(0, 7));
         in_use_imm = 1'($urandom);
         in_imm     = $urandom;
         pend.delete();
         for (int r = 1; r < 8; r++) if (m_busy[r]) pend.push_back(5'(r));
         wb_en   = 1'($urandom);
         wb_rd   = (pend.size() != 0 && $urandom_range(0, 3) != 0) ?
                   pend[$urandom_range(0, pend.size() - 1)] : 5'($urandom_range(0, 7));
         wb_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = !(m_blocks(in_rs1) || (!in_use_imm && m_blocks(in_rs2)) || m_blocks(in_rd))
                     && (!m_valid || out_ready);
         n_checks++;
         if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_ready: cyc=%0d in_ready=%b want %b rs1=%0d rs2=%0d rd=%0d imm=%b",
                     cyc, in_ready, exp_ready, in_rs1, in_rs2, in_rd, in_use_imm);
         end
         acc = in_valid && exp_ready;
         if (acc) begin
            m_valid = 1'b1;
            m_op = in_op;
            m_a = m_read(in_rs1);
            m_b = in_use_imm ? in_imm : m_read(in_rs2);
            m_rd = in_rd;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (wb_en && wb_rd != 5'd0) begin
            m_reg[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
         end
         if (acc && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
         step();
         n_checks++;
         if (out_valid !== m_valid) begin
            n_fail++; $display("FAIL rand_valid: cyc=%0d out_valid=%b want %b", cyc, out_valid, m_valid);
         end
         if (m_valid) begin
            n_checks++;
            if ({out_op, out_a, out_b, out_rd, out_illegal} !== {m_op, m_a, m_b, m_rd, !m_legal(m_op)}) begin
               n_fail++;
               $display("FAIL rand_bundle: cyc=%0d op=%h a=%h b=%h rd=%0d ill=%b want %h/%h/%h/%0d/%b",
                        cyc, out_op, out_a, out_b, out_rd, out_illegal,
                        m_op, m_a, m_b, m_rd, !m_legal(m_op));
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_add_issue();
      test_raw_bypass();
      test_stall_hold();
      test_reg0();
      test_imm();
      test_illegal();
      test_back_to_back();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch/issue stage directly upstream of the combinational `alu`. It holds the 32×32 architectural register file and accepts decoded instructions. It reads and bypasses source operands, blocks on a register scoreboard, and presents one registered `{op, a, b, rd}` bundle per cycle to the ALU. ALU results return through the write-back port, which writes the register file and clears the scoreboard.

## Interface
Parameters:
- `XLEN`, 32, operand and register width.
- `NREG`, 32, register count; register 0 is hardwired to zero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  instruction accepted this cycle when high together with `in_valid`.
- `in_op`  in  6  ALU opcode, passed through unchanged.
- `in_rd`  in  5  destination register.
- `in_rs1`, `in_rs2`  in  5 each  source registers.
- `in_use_imm`  in  1  when high, operand B is `in_imm` instead of register `rs2`.
- `in_imm`  in  XLEN  immediate.
- `wb_en`  in  1  write-back strobe.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  XLEN  write-back value.
- `out_valid`  out  1  bundle valid toward the ALU.
- `out_ready`  in  1  ALU side consumes the bundle.
- `out_op`  out  6  opcode.
- `out_a`, `out_b`  out  XLEN each  operands.
- `out_rd`  out  5  destination tag carried to write-back.
- `out_illegal`  out  1  `out_op` is not one of the 14 defined opcodes.

## Operation
- Register file: when `wb_en` is high and `wb_rd` is not 0, write `wb_data` at the clock edge. Reads of register 0 return 0.
- Operand read is combinational with write-back bypass. If `wb_en` is high, `wb_rd` equals `rs`, and `rs` is not 0, the read returns `wb_data`; otherwise it returns the register file contents. Operand B is `in_imm` when `in_use_imm` is high, and in that case `rs2` is ignored for both bypass and hazard.
- Scoreboard: 32 busy bits.
  - Hazard is high if `busy[rs1]`, `busy[rs2]` (only when `in_use_imm` is low) or `busy[rd]` is set, unless that register is being written back this same cycle.
  - Register 0 is never busy.
- Issue: `in_ready = !hazard && (!out_valid || out_ready)`. On accept:
  - the output register loads `{in_op, a, b, in_rd}`;
  - `out_valid` goes to 1;
  - `busy[in_rd]` is set when `in_rd` is not 0.
- Write-back clears `busy[wb_rd]`. If an issue sets and a write-back clears the same register in one cycle, set wins.
- Output hold: while `out_valid && !out_ready`, all `out_*` signals stay stable. When `out_ready` is high and nothing is accepted, `out_valid` goes to 0.
- `out_illegal` is decoded combinationally from `out_op` against the package opcode list. The bundle still issues normally; handling an illegal opcode is the consumer's responsibility.
- A write-back to a register that is not busy is legal: it writes the register file and leaves the scoreboard unchanged.

## Timing
- Reset (synchronous, held one or more cycles): all registers read 0, every busy bit is 0, `out_valid` is 0, and `out_op`, `out_a`, `out_b`, `out_rd` are 0.
  - `in_ready` is forced to 0 during reset.
  - A `wb_en` asserted during reset is ignored.
- Latency: an instruction accepted at edge N appears with `out_valid` high after edge N. Full throughput is one instruction per cycle when there are no hazards and `out_ready` is held high.
- Bypass is same-cycle: a write-back in cycle N unblocks and feeds an instruction accepted in cycle N.
- `in_ready` may depend combinationally on `in_rs*`, `in_rd`, `in_use_imm`, `wb_*` and `out_ready`. It does not depend on `in_valid`.
- Reset in the middle of a stall drops the pending bundle and clears the scoreboard. There is no replay.

## Structure
- Package `alu_pkg` holds:
  - the 14 opcode localparams (`ADD=011000`, `SUB=011001`, `XOR=101111`, `OR=101110`, `AND=010101`, `SRA=100100`, `SRL=100101`, `SLL=100111`, `LT=000000`, `LTU=000001`, `GT=001010`, `GTU=001011`, `EQ=001100`, `NE=001101`);
  - the `is_legal_op` function;
  - `XLEN`/`NREG` defaults.
- The `alu` module imports the same package.
- One sub-module: `regfile_2r1w`, with 2 combinational read ports, 1 synchronous write port, the register-0 rule and synchronous reset. Bypass and scoreboard logic stay in `alu_operand_fetch`.

## Test plan
- Write back r1=5 and r2=6, then issue ADD rd=3, rs1=1, rs2=2 → next cycle `out_valid=1`, `out_a=5`, `out_b=6`, `out_rd=3`; `busy[3]` is set.
- Issue SUB rd=4 with rs1=3 while `busy[3]` is set → `in_ready=0`. In the cycle where `wb_en=1`, `wb_rd=3`, `wb_data=11` → `in_ready=1` and `out_a=11` via bypass.
- Hold `out_ready=0` while a bundle is valid and offer a new instruction → `in_ready=0` and all `out_*` stable; after `out_ready=1` → the new bundle loads on the next edge.
- Register 0 checks: write back `wb_rd=0`, `wb_data=0xFFFFFFFF`, then issue XOR rs1=0, rd=0 → `out_a=0`, no stall, no busy bit set. Issue with `in_use_imm=1`, `imm=-8`, rs2 busy → no stall, `out_b=0xFFFFFFF8`.
- Issue `op=111111` → `out_illegal=1` with a normal handshake. Assert reset while a bundle is stalled → next cycle `out_valid=0`, busy all 0, r1 reads 0.
